// File: rtl/ahb3lite_sram_ws.sv
`default_nettype none
// ============================================================================
//  Module   : ahb3lite_sram_ws
//  Purpose  : AHB3-Lite slave SRAM with parametrised width, depth and wait
//             states, byte/halfword/word lanes, optional privileged-write
//             check and two-cycle ERROR response for illegal transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb3lite_sram_ws #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int PROT_CHECK  = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int         c_LANES = HDATA_SIZE / 8;
    localparam int         c_LSB   = $clog2(c_LANES);
    localparam int         c_IDXW  = $clog2(MEM_DEPTH);
    localparam logic [3:0] c_WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic [c_IDXW-1:0]       r_index;
    logic [c_LANES-1:0]      r_mask;
    logic                    r_write;
    logic [HDATA_SIZE-1:0]   r_hrdata;
    logic [HDATA_SIZE-1:0]   r_mem [MEM_DEPTH];

    logic                    w_open;
    logic                    w_accept;
    logic [HADDR_SIZE-1:0]   w_index_full;
    logic [c_IDXW-1:0]       w_index;
    logic                    w_range_err;
    logic                    w_size_err;
    logic                    w_align_err;
    logic                    w_prot_err;
    logic                    w_err;
    logic [2:0]              w_align_mask;
    logic [c_LANES-1:0]      w_lane_base;
    logic [c_LANES-1:0]      w_mask;
    logic                    w_from_wait;
    logic                    w_load;
    logic [c_IDXW-1:0]       w_load_idx;
    logic                    w_commit;
    logic [HDATA_SIZE-1:0]   w_rd_word;
    logic                    w_unused;

    // Burst type and the unused protection bits carry no meaning here
    assign w_unused = ^{HBURST, HPROT[3:2], HPROT[0]};

    // A new address phase can only be taken while the slave drives HREADYOUT high
    assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept = w_open && HSEL && HREADY && HTRANS[1];

    assign w_index_full = HADDR >> c_LSB;
    assign w_index      = w_index_full[c_IDXW-1:0];

    // Alignment mask and lane pattern selected by the transfer size
    always_comb begin
        w_align_mask = 3'b000;
        w_lane_base  = c_LANES'(1);
        case (HSIZE)
            3'd0: begin w_align_mask = 3'b000; w_lane_base = c_LANES'(1);   end
            3'd1: begin w_align_mask = 3'b001; w_lane_base = c_LANES'(3);   end
            3'd2: begin w_align_mask = 3'b011; w_lane_base = c_LANES'(15);  end
            default: begin w_align_mask = 3'b111; w_lane_base = c_LANES'(255); end
        endcase
    end

    assign w_range_err = (w_index_full >= HADDR_SIZE'(MEM_DEPTH));
    assign w_size_err  = (HSIZE > 3'(c_LSB));
    assign w_align_err = |(HADDR[2:0] & w_align_mask);
    assign w_prot_err  = (PROT_CHECK != 0) && HWRITE && !HPROT[1];
    assign w_err       = w_range_err || w_size_err || w_align_err || w_prot_err;
    assign w_mask      = w_lane_base << HADDR[c_LSB-1:0];

    // Next-state and wait-counter decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_ERR1: begin
                w_state_nxt = S_ERR2;
            end
            default: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WS;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
        endcase
    end

    assign HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
    assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign HRDATA    = r_hrdata;

    // Read data is fetched on the edge entering DATA, from the held or fresh address
    assign w_from_wait = (r_state == S_WAIT);
    assign w_load      = (w_state_nxt == S_DATA) && (w_from_wait ? !r_write : !HWRITE);
    assign w_load_idx  = w_from_wait ? r_index : w_index;
    assign w_commit    = (r_state == S_DATA) && r_write;

    // Memory word for the read, with same-edge write lanes forwarded over it
    always_comb begin
        w_rd_word = r_mem[w_load_idx];
        for (int b = 0; b < c_LANES; b++) begin
            if (w_commit && r_mask[b] && (r_index == w_load_idx)) begin
                w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // Control state, captured address phase and registered read data
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_index  <= '0;
            r_mask   <= '0;
            r_write  <= 1'b0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_index <= w_index;
                r_mask  <= w_mask;
                r_write <= HWRITE && !w_err;
            end
            if (w_load) begin
                r_hrdata <= w_rd_word;
            end
        end
    end

    // Byte-masked write commit on the edge leaving DATA; reset drops it
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_commit) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (r_mask[b]) begin
                    r_mem[r_index][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_sram_ws.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb3lite_sram_ws
//  Purpose  : Self-checking bench for ahb3lite_sram_ws. Two instances:
//             dut0 zero-wait with privileged-write check, dut1 three wait
//             states without it. Directed tables plus random traffic
//             checked against a byte-addressed reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb3lite_sram_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       hrst;
    logic [1:0]       hsel;
    logic [1:0]       hwrite;
    logic [1:0][31:0] haddr;
    logic [1:0][31:0] hwdata;
    logic [1:0][2:0]  hsize;
    logic [1:0][2:0]  hburst;
    logic [1:0][3:0]  hprot;
    logic [1:0][1:0]  htrans;
    logic [31:0]      hrdata0, hrdata1;
    logic             hreadyout0, hreadyout1;
    logic             hresp0, hresp1;

    ahb3lite_sram_ws #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0), .PROT_CHECK(1)
    ) dut0 (
        .HCLK(clk), .HRESET(hrst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
        .HRDATA(hrdata0), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
        .HPROT(hprot[0]), .HTRANS(htrans[0]), .HREADY(hreadyout0), .HREADYOUT(hreadyout0),
        .HRESP(hresp0)
    );

    ahb3lite_sram_ws #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3), .PROT_CHECK(0)
    ) dut1 (
        .HCLK(clk), .HRESET(hrst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
        .HRDATA(hrdata1), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
        .HPROT(hprot[1]), .HTRANS(htrans[1]), .HREADY(hreadyout1), .HREADYOUT(hreadyout1),
        .HRESP(hresp1)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        xq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    byte unsigned mdl   [1024];
    bit           known [1024];

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [3:0] prot, input logic [31:0] wdata,
                                input bit err, input bit chk, input logic [31:0] exp_rd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.prot = prot; v.wdata = wdata;
        v.exp_err = err; v.chk_rd = chk; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic rdy_of(input int d);
        return (d == 0) ? hreadyout0 : hreadyout1;
    endfunction
    function automatic logic rsp_of(input int d);
        return (d == 0) ? hresp0 : hresp1;
    endfunction
    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? hrdata0 : hrdata1;
    endfunction
    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0; hwrite[d] = 1'b0;
        hsize[d] = '0; hprot[d] = '0; hburst[d] = '0;
    endtask

    task automatic drive_addr(input int d, input vec_t v);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = v.addr; hwrite[d] = v.wr;
        hsize[d] = v.size; hprot[d] = v.prot; hburst[d] = 3'b001;
    endtask

    // Reference rules: range, size, alignment and (dut0 only) privileged writes
    function automatic bit classify(input int d, input vec_t v);
        int unsigned nbytes;
        nbytes = 1 << v.size;
        if ((v.addr / 4) >= 256) return 1'b1;
        if (nbytes > 4) return 1'b1;
        if ((v.addr % nbytes) != 0) return 1'b1;
        if (d == 0 && v.wr && !v.prot[1]) return 1'b1;
        return 1'b0;
    endfunction

    // Walk the queued transfers in order, filling in expectations from the model
    task automatic model_fill(input int d);
        for (int i = 0; i < xq.size(); i++) begin
            int unsigned a, base, nb;
            a  = xq[i].addr;
            nb = 1 << xq[i].size;
            xq[i].exp_err = classify(d, xq[i]);
            xq[i].chk_rd  = 1'b0;
            xq[i].exp_rd  = '0;
            if (!xq[i].exp_err) begin
                base = a - (a % 4);
                if (xq[i].wr) begin
                    for (int k = 0; k < int'(nb); k++) begin
                        mdl[a + k]   = xq[i].wdata[8*((a + k) % 4) +: 8];
                        known[a + k] = 1'b1;
                    end
                end else begin
                    xq[i].chk_rd = known[base] && known[base+1] && known[base+2] && known[base+3];
                    xq[i].exp_rd = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
                end
            end
        end
    endtask

    // Pipelined master: address phase of the next transfer overlaps the current data phase
    task automatic run(input int d);
        int   n, cur, nxt, waits, cyc;
        bit   bad_resp;
        logic rdy, rsp;
        logic [31:0] rd;
        n = xq.size(); cur = -1; nxt = 0; waits = 0; cyc = 0; bad_resp = 1'b0;
        while (cur < n) begin
            if (nxt < n) drive_addr(d, xq[nxt]);
            else         drive_idle(d);
            if (cur >= 0) hwdata[d] = xq[cur].wdata;
            else          hwdata[d] = '0;
            @(negedge clk);
            rdy = rdy_of(d); rsp = rsp_of(d); rd = rd_of(d);
            if (cur >= 0) begin
                if (rdy !== 1'b1) waits++;
                if (rsp !== 1'(xq[cur].exp_err)) bad_resp = 1'b1;
                if (rdy === 1'b1) begin
                    check($sformatf("d%0d x%0d waits", d, cur), 32'(waits),
                          32'(xq[cur].exp_err ? 1 : ws_of(d)));
                    check($sformatf("d%0d x%0d hresp(last=%0b)", d, cur, rsp), 32'(bad_resp), 32'd0);
                    if (!xq[cur].wr && !xq[cur].exp_err && xq[cur].chk_rd)
                        check($sformatf("d%0d x%0d hrdata@%h", d, cur, xq[cur].addr), rd, xq[cur].exp_rd);
                    waits = 0; bad_resp = 1'b0;
                end
            end
            cyc++;
            if (cyc > 20 * n + 50) begin
                check($sformatf("d%0d transfer timeout", d), 32'(cur), 32'(n));
                drive_idle(d);
                return;
            end
            @(posedge clk); #1;
            if (rdy === 1'b1) begin
                cur = nxt;
                nxt = nxt + 1;
            end
        end
        drive_idle(d);
        hwdata[d] = '0;
    endtask

    initial begin
        vec_t tbl0[18];
        vec_t tbl1[9];

        tbl0[0]  = mk(1, 32'h10,  3'd2, 4'h3, 32'hDEADBEEF, 0, 0, 0);
        tbl0[1]  = mk(0, 32'h10,  3'd2, 4'h3, 32'h0,        0, 1, 32'hDEADBEEF);
        tbl0[2]  = mk(1, 32'h00,  3'd2, 4'h3, 32'h55AA55AA, 0, 0, 0);
        tbl0[3]  = mk(1, 32'h20,  3'd2, 4'h3, 32'h00000000, 0, 0, 0);
        tbl0[4]  = mk(1, 32'h21,  3'd0, 4'h3, 32'h0000AA00, 0, 0, 0);
        tbl0[5]  = mk(1, 32'h22,  3'd1, 4'h3, 32'h12340000, 0, 0, 0);
        tbl0[6]  = mk(0, 32'h20,  3'd2, 4'h3, 32'h0,        0, 1, 32'h1234AA00);
        tbl0[7]  = mk(0, 32'h400, 3'd2, 4'h3, 32'h0,        1, 0, 0);
        tbl0[8]  = mk(0, 32'h01,  3'd1, 4'h3, 32'h0,        1, 0, 0);
        tbl0[9]  = mk(1, 32'h00,  3'd2, 4'h0, 32'hFFFFFFFF, 1, 0, 0);
        tbl0[10] = mk(1, 32'h00,  3'd3, 4'h3, 32'hFFFFFFFF, 1, 0, 0);
        tbl0[11] = mk(1, 32'h13,  3'd1, 4'h3, 32'hFFFFFFFF, 1, 0, 0);
        tbl0[12] = mk(1, 32'h3FC, 3'd2, 4'h3, 32'hCAFEF00D, 0, 0, 0);
        tbl0[13] = mk(0, 32'h00,  3'd2, 4'h3, 32'h0,        0, 1, 32'h55AA55AA);
        tbl0[14] = mk(0, 32'h10,  3'd2, 4'h3, 32'h0,        0, 1, 32'hDEADBEEF);
        tbl0[15] = mk(0, 32'h3FC, 3'd2, 4'h3, 32'h0,        0, 1, 32'hCAFEF00D);
        tbl0[16] = mk(0, 32'h22,  3'd1, 4'h3, 32'h0,        0, 1, 32'h1234AA00);
        tbl0[17] = mk(0, 32'h21,  3'd0, 4'h3, 32'h0,        0, 1, 32'h1234AA00);

        tbl1[0]  = mk(1, 32'h40,  3'd2, 4'h0, 32'h11111111, 0, 0, 0);
        tbl1[1]  = mk(1, 32'h44,  3'd2, 4'h0, 32'hA5A5A5A5, 0, 0, 0);
        tbl1[2]  = mk(0, 32'h44,  3'd2, 4'h0, 32'h0,        0, 1, 32'hA5A5A5A5);
        tbl1[3]  = mk(0, 32'h400, 3'd2, 4'h0, 32'h0,        1, 0, 0);
        tbl1[4]  = mk(1, 32'h42,  3'd2, 4'h0, 32'hFFFFFFFF, 1, 0, 0);
        tbl1[5]  = mk(0, 32'h40,  3'd2, 4'h0, 32'h0,        0, 1, 32'h11111111);
        tbl1[6]  = mk(1, 32'h45,  3'd0, 4'h0, 32'h00007700, 0, 0, 0);
        tbl1[7]  = mk(0, 32'h44,  3'd2, 4'h0, 32'h0,        0, 1, 32'hA5A577A5);
        tbl1[8]  = mk(0, 32'h40,  3'd2, 4'h0, 32'h0,        0, 1, 32'h11111111);

        // Reset both instances for two cycles
        drive_idle(0); drive_idle(1);
        hwdata = '0;
        hrst   = 2'b11;
        repeat (2) @(posedge clk);
        #1 hrst = 2'b00;

        // Idle, deselected and BUSY cycles must all look like zero-wait OKAY
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 2; d++) begin
                drive_idle(d);
                if (c == 1) begin htrans[d] = 2'b10; haddr[d] = 32'h10; end
                if (c == 2) begin hsel[d] = 1'b1; htrans[d] = 2'b01; haddr[d] = 32'h10; end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("reset d%0d c%0d hreadyout", d, c), 32'(rdy_of(d)), 32'd1);
                check($sformatf("reset d%0d c%0d hresp", d, c), 32'(rsp_of(d)), 32'd0);
                check($sformatf("reset d%0d c%0d hrdata", d, c), rd_of(d), 32'd0);
            end
            @(posedge clk); #1;
        end
        drive_idle(0); drive_idle(1);

        // Directed tables
        xq.delete();
        foreach (tbl0[i]) xq.push_back(tbl0[i]);
        run(0);
        xq.delete();
        foreach (tbl1[i]) xq.push_back(tbl1[i]);
        run(1);

        // Reset during the second wait cycle of a write to 0x40 on dut1
        drive_addr(1, mk(1, 32'h40, 3'd2, 4'h3, 32'hBAD0BAD0, 0, 0, 0));
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'hBAD0BAD0;
        @(negedge clk);
        check("midreset first wait hreadyout", 32'(hreadyout1), 32'd0);
        @(posedge clk); #1;
        hrst[1] = 1'b1;
        @(negedge clk);
        check("midreset second wait hreadyout", 32'(hreadyout1), 32'd0);
        @(posedge clk); #1;
        hrst[1] = 1'b0;
        @(negedge clk);
        check("midreset hreadyout", 32'(hreadyout1), 32'd1);
        check("midreset hresp", 32'(hresp1), 32'd0);
        check("midreset hrdata", hrdata1, 32'd0);
        @(posedge clk); #1;
        hwdata[1] = '0;
        xq.delete();
        xq.push_back(mk(0, 32'h40, 3'd2, 4'h0, 32'h0, 0, 1, 32'h11111111));
        run(1);

        // Randomised traffic against the byte-level reference memory
        for (int d = 0; d < 2; d++) begin
            foreach (known[i]) known[i] = 1'b0;
            xq.delete();
            for (int w = 0; w < 16; w++)
                xq.push_back(mk(1, 32'(w * 4), 3'd2, 4'h3, $urandom, 0, 0, 0));
            for (int i = 0; i < 150; i++) begin
                int unsigned r;
                logic [31:0] a;
                r = $urandom_range(0, 15);
                if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
                else if (r == 1) a = $urandom;
                else             a = 32'($urandom_range(0, 63));
                xq.push_back(mk(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 3)),
                                4'($urandom_range(0, 15)), $urandom, 0, 0, 0));
            end
            model_fill(d);
            run(d);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
